// File: rtl/four_bit_1to2demux_buf_pkg.sv
// rtl/four_bit_1to2demux_buf_pkg.sv - shared defaults and channel select encodings for the buffered 1-to-2 demux
package four_bit_1to2demux_buf_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 2;
    localparam int CNT_W_DEF = 8;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/four_bit_1to2demux_buf_sync_fifo.sv
// rtl/four_bit_1to2demux_buf_sync_fifo.sv - single-clock FIFO with wrap-bit pointers and zeroed output when empty
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Guard locally so a misbehaving caller can never corrupt occupancy.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: stale entries are never visible because dout is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/four_bit_1to2demux_buf.sv
// rtl/four_bit_1to2demux_buf.sv - steers one valid/ready stream into two independently buffered channels
module four_bit_1to2demux_buf
    import four_bit_1to2demux_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic full_a;
    logic full_b;
    logic empty_a;
    logic empty_b;
    logic acc;
    logic push_a;
    logic push_b;
    logic pop_a;
    logic pop_b;

    // Ready depends only on the selected FIFO's fullness, never on a_ready/b_ready.
    assign in_ready = (in_sel == SEL_B) ? ~full_b : ~full_a;
    assign acc      = in_valid & in_ready;
    assign push_a   = acc & ~in_sel;
    assign push_b   = acc & in_sel;

    assign a_valid = ~empty_a;
    assign b_valid = ~empty_b;
    assign pop_a   = a_valid & a_ready;
    assign pop_b   = b_valid & b_ready;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) fifo_a (
        .clk   (clk),
        .reset (reset),
        .push  (push_a),
        .din   (in_data),
        .full  (full_a),
        .pop   (pop_a),
        .dout  (a_data),
        .empty (empty_a)
    );

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) fifo_b (
        .clk   (clk),
        .reset (reset),
        .push  (push_b),
        .din   (in_data),
        .full  (full_b),
        .pop   (pop_b),
        .dout  (b_data),
        .empty (empty_b)
    );

    // Delivered-word counters wrap silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (pop_a) begin
                a_count <= a_count + CNT_ONE;
            end
            if (pop_b) begin
                b_count <= b_count + CNT_ONE;
            end
        end
    end

endmodule
